// File: rtl/fp16_to_int16_converter_pkg.sv
// ---------------------------------------------------------------------------
// fp16_to_int16_converter_pkg
// Shared definitions for the FP16 -> INT16 converter and its classifier:
//   - FP16 field positions, exponent bias, all-ones exponent
//   - converter FSM state encoding
//   - INT16 special result codes
//   - special_result(): result word for NaN / Inf / out-of-range operands
// Build option: define FP2INT_SATURATE_EN to saturate out-of-range results
// (+ -> 16'h7FFF, - -> 16'h8000, NaN -> 16'h0000). Without it every
// out-of-range, Inf or NaN operand returns the integer indefinite 16'h8000.
// ---------------------------------------------------------------------------
package fp16_to_int16_converter_pkg;

   localparam int FP16_SIGN_POS = 15;
   localparam int FP16_EXP_MSB  = 14;
   localparam int FP16_EXP_LSB  = 10;
   localparam int FP16_MANT_MSB = 9;
   localparam int FP16_MANT_W   = 10;
   localparam int FP16_BIAS     = 15;

   localparam logic [4:0] FP16_EXP_MAX = 5'h1F;

   // Exponent at which {hidden, mant} already equals the integer value
   localparam logic [4:0] EXP_UNITY_SHIFT = 5'(FP16_BIAS + FP16_MANT_W);
   // Smallest exponent whose magnitude can no longer fit a positive int16
   localparam logic [4:0] EXP_INT_OVF     = 5'd30;

   // The single exp==30 operand that is representable: -32768
   localparam logic [15:0] FP16_NEG_32768   = 16'hF800;

   localparam logic [15:0] INT16_INDEFINITE = 16'h8000;
   localparam logic [15:0] INT16_MAX        = 16'h7FFF;
   localparam logic [15:0] INT16_MIN        = 16'h8000;
   localparam logic [15:0] INT16_ZERO       = 16'h0000;

`ifdef FP2INT_SATURATE_EN
   localparam logic SATURATE_EN = 1'b1;
`else
   localparam logic SATURATE_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_ROUND = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Result word for NaN, Inf and out-of-range operands
   function automatic logic [15:0] special_result(input logic sign, input logic is_nan);
      logic [15:0] res;
      if (SATURATE_EN) begin
         if (is_nan) begin
            res = INT16_ZERO;
         end else if (sign) begin
            res = INT16_MIN;
         end else begin
            res = INT16_MAX;
         end
      end else begin
         res = INT16_INDEFINITE;
      end
      return res;
   endfunction

endpackage

// File: rtl/fp16_classify.sv
// ---------------------------------------------------------------------------
// fp16_classify
// Purely combinational FP16 operand classifier, shared with the FP16
// add/sub special-case logic.
// Ports:
//   x        in  16  FP16 operand {sign, exp[4:0], mant[9:0]}
//   is_neg   out 1   sign bit set
//   is_zero  out 1   +/-0
//   is_sub   out 1   subnormal (exp==0, mant!=0)
//   is_inf   out 1   +/-Inf
//   is_nan   out 1   any NaN
// ---------------------------------------------------------------------------
module fp16_classify
   import fp16_to_int16_converter_pkg::*;
(
   input  logic [15:0] x,
   output logic        is_neg,
   output logic        is_zero,
   output logic        is_sub,
   output logic        is_inf,
   output logic        is_nan
);

   logic [4:0] exp_s;
   logic       mant_nz_s;

   assign exp_s     = x[FP16_EXP_MSB:FP16_EXP_LSB];
   assign mant_nz_s = |x[FP16_MANT_MSB:0];

   assign is_neg  = x[FP16_SIGN_POS];
   assign is_zero = (exp_s == 5'd0) && !mant_nz_s;
   assign is_sub  = (exp_s == 5'd0) &&  mant_nz_s;
   assign is_inf  = (exp_s == FP16_EXP_MAX) && !mant_nz_s;
   assign is_nan  = (exp_s == FP16_EXP_MAX) &&  mant_nz_s;

endmodule

// File: rtl/fp16_to_int16_converter.sv
// ---------------------------------------------------------------------------
// fp16_to_int16_converter
// Iterative FP16 -> signed INT16 converter, one operand in flight, one
// shift step per cycle, valid/ready on both sides.
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid / in_ready   operand handshake; in_ready high only in IDLE
//   x, round_mode         FP16 operand; 0 = truncate, 1 = nearest-even
//   out_valid / out_ready result handshake; result held until taken
//   r                     signed integer result
//   invalid               operand was NaN
//   overflow              operand was Inf or outside [-32768, 32767]
//   inexact               fractional bits discarded on the finite path
// Parameter:
//   MAX_RSHIFT            clamp on right-shift count
// Build option: FP2INT_SATURATE_EN selects saturating special results.
// ---------------------------------------------------------------------------
module fp16_to_int16_converter
   import fp16_to_int16_converter_pkg::*;
#(
   parameter int MAX_RSHIFT = 12
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] x,
   input  logic        round_mode,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] r,
   output logic        invalid,
   output logic        overflow,
   output logic        inexact
);

   localparam logic [4:0] MAX_RSHIFT_C = 5'(MAX_RSHIFT);

   logic [4:0]  exp_s;
   logic [9:0]  mant_s;
   logic        is_neg_s, is_zero_s, is_sub_s, is_inf_s, is_nan_s;

   logic [15:0] acc_mag_s;
   logic [4:0]  acc_cnt_s;
   logic [4:0]  rshift_s;
   logic        acc_dir_right_s;
   logic        acc_special_s;
   logic [15:0] acc_res_s;
   logic        acc_ovf_s;
   logic        acc_inv_s;

   logic        inc_s;
   logic [15:0] mag_rnd_s;
   logic [15:0] round_res_s;

   state_t      state_r;
   logic [15:0] mag_r;
   logic [4:0]  cnt_r;
   logic        dir_right_r;
   logic        guard_r;
   logic        sticky_r;
   logic        sign_r;
   logic        rm_r;
   logic        special_r;
   logic [15:0] spec_res_r;
   logic        spec_ovf_r;
   logic        spec_inv_r;
   logic        out_valid_r;
   logic [15:0] result_r;
   logic        invalid_r;
   logic        overflow_r;
   logic        inexact_r;

   assign exp_s  = x[FP16_EXP_MSB:FP16_EXP_LSB];
   assign mant_s = x[FP16_MANT_MSB:0];

   fp16_classify u_classify (
      .x       (x),
      .is_neg  (is_neg_s),
      .is_zero (is_zero_s),
      .is_sub  (is_sub_s),
      .is_inf  (is_inf_s),
      .is_nan  (is_nan_s)
   );

   // Hidden bit is present for every exponent except zero
   assign acc_mag_s = {5'd0, ~(is_zero_s | is_sub_s), mant_s};
   assign rshift_s  = EXP_UNITY_SHIFT - exp_s;

   // Decode the operand at accept: shift direction/count or a special result
   always_comb begin
      acc_cnt_s       = 5'd0;
      acc_dir_right_s = 1'b1;
      acc_special_s   = 1'b0;
      acc_res_s       = INT16_ZERO;
      acc_ovf_s       = 1'b0;
      acc_inv_s       = 1'b0;
      if (is_nan_s) begin
         acc_special_s = 1'b1;
         acc_inv_s     = 1'b1;
         acc_res_s     = special_result(is_neg_s, 1'b1);
      end else if (is_inf_s) begin
         acc_special_s = 1'b1;
         acc_ovf_s     = 1'b1;
         acc_res_s     = special_result(is_neg_s, 1'b0);
      end else if (exp_s == EXP_INT_OVF) begin
         acc_special_s = 1'b1;
         if (x == FP16_NEG_32768) begin
            acc_res_s = INT16_MIN;
         end else begin
            acc_ovf_s = 1'b1;
            acc_res_s = special_result(is_neg_s, 1'b0);
         end
      end else if (exp_s >= EXP_UNITY_SHIFT) begin
         acc_dir_right_s = 1'b0;
         acc_cnt_s       = exp_s - EXP_UNITY_SHIFT;
      end else begin
         // exp==0 also lands here with a deficit of 25, always clamped
         if (rshift_s > MAX_RSHIFT_C) begin
            acc_cnt_s = MAX_RSHIFT_C;
         end else begin
            acc_cnt_s = rshift_s;
         end
      end
   end

   // Round-to-nearest-even increment and sign application
   always_comb begin
      inc_s       = rm_r & guard_r & (sticky_r | mag_r[0]);
      mag_rnd_s   = mag_r + {15'd0, inc_s};
      if (sign_r) begin
         round_res_s = 16'd0 - mag_rnd_s;
      end else begin
         round_res_s = mag_rnd_s;
      end
   end

   // Converter FSM: accept, shift one bit per cycle, round, hold result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         mag_r       <= 16'd0;
         cnt_r       <= 5'd0;
         dir_right_r <= 1'b1;
         guard_r     <= 1'b0;
         sticky_r    <= 1'b0;
         sign_r      <= 1'b0;
         rm_r        <= 1'b0;
         special_r   <= 1'b0;
         spec_res_r  <= 16'd0;
         spec_ovf_r  <= 1'b0;
         spec_inv_r  <= 1'b0;
         out_valid_r <= 1'b0;
         result_r    <= 16'd0;
         invalid_r   <= 1'b0;
         overflow_r  <= 1'b0;
         inexact_r   <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (in_valid) begin
                  mag_r       <= acc_mag_s;
                  cnt_r       <= acc_cnt_s;
                  dir_right_r <= acc_dir_right_s;
                  guard_r     <= 1'b0;
                  sticky_r    <= 1'b0;
                  sign_r      <= is_neg_s;
                  rm_r        <= round_mode;
                  special_r   <= acc_special_s;
                  spec_res_r  <= acc_res_s;
                  spec_ovf_r  <= acc_ovf_s;
                  spec_inv_r  <= acc_inv_s;
                  // Specials skip SHIFT so the result appears one edge after accept
                  state_r     <= acc_special_s ? ST_ROUND : ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (cnt_r == 5'd0) begin
                  state_r <= ST_ROUND;
               end else begin
                  cnt_r <= cnt_r - 5'd1;
                  if (dir_right_r) begin
                     mag_r    <= {1'b0, mag_r[15:1]};
                     guard_r  <= mag_r[0];
                     sticky_r <= sticky_r | guard_r;
                  end else begin
                     mag_r <= {mag_r[14:0], 1'b0};
                  end
               end
            end
            ST_ROUND: begin
               if (special_r) begin
                  result_r   <= spec_res_r;
                  overflow_r <= spec_ovf_r;
                  invalid_r  <= spec_inv_r;
                  inexact_r  <= 1'b0;
               end else begin
                  result_r   <= round_res_s;
                  overflow_r <= 1'b0;
                  invalid_r  <= 1'b0;
                  inexact_r  <= guard_r | sticky_r;
               end
               out_valid_r <= 1'b1;
               state_r     <= ST_DONE;
            end
            ST_DONE: begin
               if (out_ready) begin
                  out_valid_r <= 1'b0;
                  state_r     <= ST_IDLE;
               end
            end
            default: begin
               out_valid_r <= 1'b0;
               state_r     <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = (state_r == ST_IDLE);
   assign out_valid = out_valid_r;
   assign r         = result_r;
   assign invalid   = invalid_r;
   assign overflow  = overflow_r;
   assign inexact   = inexact_r;

endmodule

// File: tb/tb_fp16_to_int16_converter.sv
// ---------------------------------------------------------------------------
// tb_fp16_to_int16_converter
// Table-driven bench with a result scoreboard, plus hand-written sequences
// for output backpressure and reset during a conversion.
// ---------------------------------------------------------------------------
module tb_fp16_to_int16_converter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] x = 16'h0000;
   logic        round_mode = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] r;
   logic        invalid;
   logic        overflow;
   logic        inexact;

`ifdef FP2INT_SATURATE_EN
   localparam logic [15:0] POS_OVF_R = 16'h7FFF;
   localparam logic [15:0] NAN_R     = 16'h0000;
`else
   localparam logic [15:0] POS_OVF_R = 16'h8000;
   localparam logic [15:0] NAN_R     = 16'h8000;
`endif

   fp16_to_int16_converter #(.MAX_RSHIFT(12)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .x          (x),
      .round_mode (round_mode),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .r          (r),
      .invalid    (invalid),
      .overflow   (overflow),
      .inexact    (inexact)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] x;
      logic        rm;
      logic [15:0] r;
      logic        inv;
      logic        ovf;
      logic        inx;
      int          lat;
   } vec_t;

   typedef struct {
      logic [15:0] r;
      logic        inv;
      logic        ovf;
      logic        inx;
      int          lat;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic note_timeout(input string name);
      n_vec++;
      n_err++;
      $display("FAIL %s: timed out waiting on DUT", name);
   endtask

   // Drive one operand; returns after the accepting edge (+1 time unit)
   task automatic issue(input logic [15:0] xv, input logic rmv, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 50 && !ok; c++) begin
         @(negedge clk);
         if (in_ready) ok = 1'b1;
      end
      if (ok) begin
         x          = xv;
         round_mode = rmv;
         in_valid   = 1'b1;
         @(posedge clk);
         #1;
         in_valid   = 1'b0;
      end
   endtask

   // Count edges after the accepting edge until out_valid is seen
   task automatic wait_out(output int lat, output bit got);
      lat = 0;
      got = 1'b0;
      for (int c = 0; c <= 40 && !got; c++) begin
         @(negedge clk);
         if (out_valid) begin
            got = 1'b1;
            lat = c;
         end else begin
            @(posedge clk);
         end
      end
   endtask

   task automatic run_vec(input vec_t v, input int i);
      bit   ok;
      bit   got;
      int   lat;
      exp_t e;
      issue(v.x, v.rm, ok);
      if (!ok) begin
         note_timeout($sformatf("v%0d accept", i));
      end else begin
         sb.push_back(exp_t'{v.r, v.inv, v.ovf, v.inx, v.lat});
         wait_out(lat, got);
         if (!got) begin
            note_timeout($sformatf("v%0d result", i));
            void'(sb.pop_front());
         end else begin
            e = sb.pop_front();
            chk($sformatf("v%0d x=%h latency", i, v.x), 32'(lat), 32'(e.lat));
            chk($sformatf("v%0d x=%h r", i, v.x), {16'd0, r}, {16'd0, e.r});
            chk($sformatf("v%0d x=%h flags", i, v.x),
                {29'd0, invalid, overflow, inexact}, {29'd0, e.inv, e.ovf, e.inx});
            chk($sformatf("v%0d in_ready in DONE", i), {31'd0, in_ready}, 32'd0);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d out_valid after take", i), {31'd0, out_valid}, 32'd0);
         end
      end
   endtask

   initial begin
      bit   ok;
      bit   got;
      bit   saw_valid;
      int   lat;
      exp_t e;

      // {x, round_mode, r, invalid, overflow, inexact, latency}
      vecs.push_back(vec_t'{16'h4500, 1'b1, 16'h0005, 1'b0, 1'b0, 1'b0, 10});
      vecs.push_back(vec_t'{16'h4100, 1'b1, 16'h0002, 1'b0, 1'b0, 1'b1, 11});
      vecs.push_back(vec_t'{16'h4300, 1'b1, 16'h0004, 1'b0, 1'b0, 1'b1, 11});
      vecs.push_back(vec_t'{16'hC300, 1'b0, 16'hFFFD, 1'b0, 1'b0, 1'b1, 11});
      vecs.push_back(vec_t'{16'hF800, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b0, 1});
      vecs.push_back(vec_t'{16'h7800, 1'b0, POS_OVF_R, 1'b0, 1'b1, 1'b0, 1});
      vecs.push_back(vec_t'{16'h7E00, 1'b1, NAN_R, 1'b1, 1'b0, 1'b0, 1});
      vecs.push_back(vec_t'{16'h0001, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 14});
      vecs.push_back(vec_t'{16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 14});
      vecs.push_back(vec_t'{16'h8000, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 14});
      vecs.push_back(vec_t'{16'h77FF, 1'b1, 16'h7FF0, 1'b0, 1'b0, 1'b0, 6});
      vecs.push_back(vec_t'{16'hF7FF, 1'b0, 16'h8010, 1'b0, 1'b0, 1'b0, 6});
      vecs.push_back(vec_t'{16'h6400, 1'b0, 16'h0400, 1'b0, 1'b0, 1'b0, 2});
      vecs.push_back(vec_t'{16'h3C00, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0, 12});
      vecs.push_back(vec_t'{16'h3800, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 13});
      vecs.push_back(vec_t'{16'h3A00, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b1, 13});
      vecs.push_back(vec_t'{16'h3A00, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 13});
      vecs.push_back(vec_t'{16'h3E00, 1'b1, 16'h0002, 1'b0, 1'b0, 1'b1, 12});
      vecs.push_back(vec_t'{16'hC100, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b1, 11});
      vecs.push_back(vec_t'{16'h0400, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 14});
      vecs.push_back(vec_t'{16'hFE00, 1'b0, NAN_R, 1'b1, 1'b0, 1'b0, 1});
      vecs.push_back(vec_t'{16'hF801, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1});
      vecs.push_back(vec_t'{16'h7C00, 1'b0, POS_OVF_R, 1'b0, 1'b1, 1'b0, 1});
      vecs.push_back(vec_t'{16'hFC00, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1});
      vecs.push_back(vec_t'{16'h5640, 1'b1, 16'h0064, 1'b0, 1'b0, 1'b0, 6});
      vecs.push_back(vec_t'{16'h7BFF, 1'b1, POS_OVF_R, 1'b0, 1'b1, 1'b0, 1});

      // Reset state
      #12;
      chk("reset out_valid", {31'd0, out_valid}, 32'd0);
      chk("reset r", {16'd0, r}, 32'd0);
      chk("reset flags", {29'd0, invalid, overflow, inexact}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("in_ready after reset", {31'd0, in_ready}, 32'd1);

      foreach (vecs[i]) run_vec(vecs[i], i);

      // Backpressure: result held while out_ready is low, no new accept
      out_ready = 1'b0;
      issue(16'h4500, 1'b1, ok);
      if (!ok) begin
         note_timeout("stall accept");
      end else begin
         sb.push_back(exp_t'{16'h0005, 1'b0, 1'b0, 1'b0, 10});
         wait_out(lat, got);
         if (!got) begin
            note_timeout("stall result");
            void'(sb.pop_front());
         end else begin
            e = sb.pop_front();
            for (int k = 0; k < 5; k++) begin
               @(negedge clk);
               x        = 16'h7E00;
               in_valid = 1'b1;
               chk($sformatf("stall%0d out_valid", k), {31'd0, out_valid}, 32'd1);
               chk($sformatf("stall%0d r", k), {16'd0, r}, {16'd0, e.r});
               chk($sformatf("stall%0d flags", k), {29'd0, invalid, overflow, inexact},
                   {29'd0, e.inv, e.ovf, e.inx});
               chk($sformatf("stall%0d in_ready", k), {31'd0, in_ready}, 32'd0);
            end
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            chk("stall release out_valid", {31'd0, out_valid}, 32'd0);
            chk("stall release in_ready", {31'd0, in_ready}, 32'd1);
         end
      end
      out_ready = 1'b1;

      // Reset in the middle of SHIFT aborts the conversion
      issue(16'h0001, 1'b0, ok);
      if (!ok) begin
         note_timeout("abort accept");
      end else begin
         repeat (3) @(posedge clk);
         @(negedge clk);
         rst_n = 1'b0;
         #1;
         chk("abort out_valid", {31'd0, out_valid}, 32'd0);
         @(negedge clk);
         rst_n = 1'b1;
         saw_valid = 1'b0;
         for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid) saw_valid = 1'b1;
         end
         chk("abort no emission", {31'd0, saw_valid}, 32'd0);
         chk("abort in_ready", {31'd0, in_ready}, 32'd1);
      end

      // Converter still works after the aborted conversion
      run_vec(vec_t'{16'h3C00, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, 12}, 99);

      chk("scoreboard empty", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
